// File: rtl/wb_reg_file_pkg.sv
// ---------------------------------------------------------------------------
// wb_reg_file_pkg
// Shared constants for the writeback register file slice:
//   - result-select encodings driven on mem_to_reg_wb
//   - GPR address width, the link register index and the hardwired zero reg
// ---------------------------------------------------------------------------
package wb_reg_file_pkg;

    localparam int ADDR_W = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_HI  = 2'b10;
    localparam logic [1:0] RES_LO  = 2'b11;

    localparam int LINK_REG = 31;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : wb_reg_file_pkg

// File: rtl/wb_reg_file_gpr_array.sv
// ---------------------------------------------------------------------------
// wb_reg_file_gpr_array
// General-purpose register storage: one synchronous write port, two
// combinational read ports with same-cycle write-to-read bypass.
// Register 0 is never stored and always reads as zero, bypass included.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   we, waddr, wdata   write port, committed on the rising edge
//   raddr_a, rdata_a   read port A (combinational)
//   raddr_b, rdata_b   read port B (combinational)
// ---------------------------------------------------------------------------
module wb_reg_file_gpr_array
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
)
(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  we,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]                     wdata,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]    raddr_a,
    output logic [DATA_W-1:0]                     rdata_a,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]    raddr_b,
    output logic [DATA_W-1:0]                     rdata_b
);
    import wb_reg_file_pkg::*;

    logic [DATA_W-1:0] regs [NREGS];

    // Writes to r0 are dropped here so the storage for r0 stays at its reset
    // value; the read path also forces zero so r0 never depends on storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass lets the decode stage see a value being committed this cycle.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == REG_ZERO) begin
            rdata_a = '0;
        end else if (we && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == REG_ZERO) begin
            rdata_b = '0;
        end else if (we && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule : wb_reg_file_gpr_array

// File: rtl/wb_reg_file.sv
// ---------------------------------------------------------------------------
// wb_reg_file
// Writeback stage: selects the writeback result (ALU, load, HI, LO or link
// PC+4), commits it to the GPR array and updates the HI/LO pair. Serves the
// two decode read ports and exports result/destination for forwarding.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   alu_out_wb, read_data_wb         ALU result, load data
//   write_reg_wb, reg_write_wb       destination GPR and its write enable
//   mem_to_reg_wb                    result select (ALU/load/HI/LO)
//   link_wb, pc_plus_4_wb            link write of the return address to LINK_REG
//   hi_out_wb, lo_out_wb,
//   hilo_write_wb                    HI/LO update values and enable
//   rs_addr/rs_data, rt_addr/rt_data decode read ports (bypassed)
//   hi_q, lo_q                       architectural HI/LO
//   result_wb, dest_wb               selected value and effective destination
// ---------------------------------------------------------------------------
module wb_reg_file
#(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int LINK_REG = wb_reg_file_pkg::LINK_REG
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_W-1:0]                   alu_out_wb,
    input  logic [DATA_W-1:0]                   read_data_wb,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]  write_reg_wb,
    input  logic                                reg_write_wb,
    input  logic [1:0]                          mem_to_reg_wb,
    input  logic                                link_wb,
    input  logic [DATA_W-1:0]                   pc_plus_4_wb,
    input  logic [DATA_W-1:0]                   hi_out_wb,
    input  logic [DATA_W-1:0]                   lo_out_wb,
    input  logic                                hilo_write_wb,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]  rs_addr,
    input  logic [wb_reg_file_pkg::ADDR_W-1:0]  rt_addr,
    output logic [DATA_W-1:0]                   rs_data,
    output logic [DATA_W-1:0]                   rt_data,
    output logic [DATA_W-1:0]                   hi_q,
    output logic [DATA_W-1:0]                   lo_q,
    output logic [DATA_W-1:0]                   result_wb,
    output logic [wb_reg_file_pkg::ADDR_W-1:0]  dest_wb
);
    import wb_reg_file_pkg::ADDR_W;
    import wb_reg_file_pkg::RES_ALU;
    import wb_reg_file_pkg::RES_MEM;
    import wb_reg_file_pkg::RES_HI;
    import wb_reg_file_pkg::RES_LO;
    import wb_reg_file_pkg::REG_ZERO;

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic gpr_we;

    // HI/LO selections read the committed registers, so an mfhi/mflo in the
    // same cycle as a HI/LO update sees the old value.
    always_comb begin
        result_wb = alu_out_wb;
        dest_wb   = write_reg_wb;
        if (link_wb) begin
            result_wb = pc_plus_4_wb;
            dest_wb   = LINK_ADDR;
        end else begin
            unique case (mem_to_reg_wb)
                RES_ALU: result_wb = alu_out_wb;
                RES_MEM: result_wb = read_data_wb;
                RES_HI:  result_wb = hi_q;
                RES_LO:  result_wb = lo_q;
                default: result_wb = alu_out_wb;
            endcase
        end
    end

    assign gpr_we = (reg_write_wb | link_wb) && (dest_wb != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_write_wb) begin
            hi_q <= hi_out_wb;
            lo_q <= lo_out_wb;
        end
    end

    wb_reg_file_gpr_array #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_gpr (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (gpr_we),
        .waddr   (dest_wb),
        .wdata   (result_wb),
        .raddr_a (rs_addr),
        .rdata_a (rs_data),
        .raddr_b (rt_addr),
        .rdata_b (rt_data)
    );

endmodule : wb_reg_file

// File: tb/tb_wb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_wb_reg_file
// Directed bench for wb_reg_file. A behavioural model (array of 32 registers
// plus HI/LO) tracks architectural state; one compare process checks every
// output against it at each falling edge. Hand-computed literal expectations
// are queued in exp_q and popped by check_lit at fixed points.
// ---------------------------------------------------------------------------
module tb_wb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out_wb;
    logic [31:0] read_data_wb;
    logic [4:0]  write_reg_wb;
    logic        reg_write_wb;
    logic [1:0]  mem_to_reg_wb;
    logic        link_wb;
    logic [31:0] pc_plus_4_wb;
    logic [31:0] hi_out_wb;
    logic [31:0] lo_out_wb;
    logic        hilo_write_wb;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] result_wb;
    logic [4:0]  dest_wb;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          cmp_en = 0;

    wb_reg_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_out_wb    (alu_out_wb),
        .read_data_wb  (read_data_wb),
        .write_reg_wb  (write_reg_wb),
        .reg_write_wb  (reg_write_wb),
        .mem_to_reg_wb (mem_to_reg_wb),
        .link_wb       (link_wb),
        .pc_plus_4_wb  (pc_plus_4_wb),
        .hi_out_wb     (hi_out_wb),
        .lo_out_wb     (lo_out_wb),
        .hilo_write_wb (hilo_write_wb),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .hi_q          (hi_q),
        .lo_q          (lo_q),
        .result_wb     (result_wb),
        .dest_wb       (dest_wb)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [31:0] m_result();
        if (link_wb) return pc_plus_4_wb;
        case (mem_to_reg_wb)
            2'd0:    return alu_out_wb;
            2'd1:    return read_data_wb;
            2'd2:    return m_hi;
            default: return m_lo;
        endcase
    endfunction

    function automatic logic [4:0] m_dest();
        return link_wb ? 5'd31 : write_reg_wb;
    endfunction

    function automatic bit m_writes();
        return (reg_write_wb || link_wb) && (m_dest() != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_writes() && a == m_dest()) return m_result();
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            logic [31:0] r;
            logic [4:0]  d;
            bit          w;
            r = m_result();
            d = m_dest();
            w = m_writes();
            if (w) m_regs[d] = r;
            if (hilo_write_wb) begin
                m_hi = hi_out_wb;
                m_lo = lo_out_wb;
            end
        end
    end

    // ---------------- compare process ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("rs_data",   rs_data,   m_read(rs_addr));
            cmp("rt_data",   rt_data,   m_read(rt_addr));
            cmp("hi_q",      hi_q,      m_hi);
            cmp("lo_q",      lo_q,      m_lo);
            cmp("result_wb", result_wb, m_result());
            cmp("dest_wb",   {27'd0, dest_wb}, {27'd0, m_dest()});
        end
    end

    // ---------------- scoreboard for literal expectations ----------------
    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_lit(input string name, input logic [31:0] act);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h but no expectation queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        alu_out_wb    = 32'd0;
        read_data_wb  = 32'd0;
        write_reg_wb  = 5'd0;
        reg_write_wb  = 1'b0;
        mem_to_reg_wb = 2'd0;
        link_wb       = 1'b0;
        pc_plus_4_wb  = 32'd0;
        hi_out_wb     = 32'd0;
        lo_out_wb     = 32'd0;
        hilo_write_wb = 1'b0;
    endtask

    // Move to 1 time unit after the next rising edge, then drive.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [1:0] sel, input logic [4:0] wr,
                            input logic [31:0] alu, input logic [31:0] mem);
        next_cycle();
        idle_inputs();
        reg_write_wb  = 1'b1;
        mem_to_reg_wb = sel;
        write_reg_wb  = wr;
        alu_out_wb    = alu;
        read_data_wb  = mem;
    endtask

    task automatic drive_idle(input logic [4:0] ra, input logic [4:0] rb);
        next_cycle();
        idle_inputs();
        rs_addr = ra;
        rt_addr = rb;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle_inputs();
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1;

        // reset then read
        drive_idle(5'd5, 5'd31);
        #2;
        expect_val(32'd0); check_lit("reset_rs5", rs_data);
        expect_val(32'd0); check_lit("reset_rt31", rt_data);
        expect_val(32'd0); check_lit("reset_hi", hi_q);
        expect_val(32'd0); check_lit("reset_lo", lo_q);

        // ALU write with bypass
        drive_wr(2'd0, 5'd8, 32'h1234_5678, 32'h0);
        rs_addr = 5'd8;
        #2;
        expect_val(32'h1234_5678); check_lit("bypass_r8", rs_data);
        drive_idle(5'd8, 5'd0);
        #2;
        expect_val(32'h1234_5678); check_lit("stored_r8", rs_data);

        // r0 protection
        drive_wr(2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
        rs_addr = 5'd0;
        #2;
        expect_val(32'd0); check_lit("r0_write_cycle", rs_data);
        drive_idle(5'd0, 5'd0);
        #2;
        expect_val(32'd0); check_lit("r0_after", rs_data);

        // link: mem_to_reg and write_reg ignored
        drive_wr(2'd1, 5'd3, 32'h0, 32'hDEAD_BEEF);
        link_wb      = 1'b1;
        pc_plus_4_wb = 32'h0040_0010;
        #2;
        expect_val(32'h0040_0010); check_lit("link_result", result_wb);
        expect_val(32'd31);        check_lit("link_dest", {27'd0, dest_wb});
        drive_idle(5'd31, 5'd3);
        #2;
        expect_val(32'h0040_0010); check_lit("link_r31", rs_data);
        expect_val(32'd0);         check_lit("link_r3_unchanged", rt_data);

        // HI/LO same-cycle hazard: mfhi gets old HI
        drive_wr(2'd2, 5'd9, 32'h0, 32'h0);
        hilo_write_wb = 1'b1;
        hi_out_wb     = 32'hA;
        lo_out_wb     = 32'hB;
        #2;
        expect_val(32'd0); check_lit("mfhi_old", result_wb);
        drive_wr(2'd3, 5'd10, 32'h0, 32'h0);
        rs_addr = 5'd9;
        #2;
        expect_val(32'd0);  check_lit("r9_old_hi", rs_data);
        expect_val(32'hA);  check_lit("hi_new", hi_q);
        expect_val(32'hB);  check_lit("mflo_result", result_wb);
        drive_idle(5'd10, 5'd9);
        #2;
        expect_val(32'hB); check_lit("r10_lo", rs_data);

        // assorted writes across registers and sources, read both ports
        for (int i = 1; i < 32; i += 3) begin
            drive_wr(2'(i % 4), 5'(i), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
            rs_addr = 5'(i);
            rt_addr = 5'(i - 1);
        end
        for (int i = 0; i < 32; i += 2) drive_idle(5'(i), 5'(i + 1));

        // enables low with arbitrary data: no state change
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            alu_out_wb    = $urandom;
            read_data_wb  = $urandom;
            pc_plus_4_wb  = $urandom;
            hi_out_wb     = $urandom;
            lo_out_wb     = $urandom;
            write_reg_wb  = 5'($urandom_range(0, 31));
            mem_to_reg_wb = 2'($urandom_range(0, 3));
            reg_write_wb  = 1'b0;
            link_wb       = 1'b0;
            hilo_write_wb = 1'b0;
            rs_addr       = 5'($urandom_range(0, 31));
            rt_addr       = 5'($urandom_range(0, 31));
        end
        expect_val(32'h1234_5678);
        drive_idle(5'd8, 5'd0);
        #2;
        check_lit("r8_survives_disabled", rs_data);

        // async reset mid-operation, between edges
        drive_wr(2'd0, 5'd4, 32'h55, 32'h0);
        drive_idle(5'd4, 5'd8);
        #2;
        expect_val(32'h55); check_lit("r4_written", rs_data);
        rst_n = 1'b0;
        #1;
        expect_val(32'd0); check_lit("r4_async_reset", rs_data);
        expect_val(32'd0); check_lit("r8_async_reset", rt_data);
        expect_val(32'd0); check_lit("hi_async_reset", hi_q);
        // write pending while reset asserted is lost
        reg_write_wb = 1'b1;
        write_reg_wb = 5'd6;
        alu_out_wb   = 32'h66;
        @(posedge clk);
        #1;
        idle_inputs();
        #2 rst_n = 1'b1;
        // first write after release
        drive_wr(2'd1, 5'd6, 32'h0, 32'h77);
        drive_idle(5'd6, 5'd4);
        #2;
        expect_val(32'h77); check_lit("first_write_after_reset", rs_data);
        expect_val(32'd0);  check_lit("r4_still_zero", rt_data);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // safety bound on total run time
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_reg_file
